exception_unit: RTL and testbench

EXCEPTION_UNIT -- requirements
Module: exception_unit

---
 rtl/exc_pkg.sv | 35 +++
 rtl/exc_sysregs.sv | 53 +++++
 rtl/exception_unit.sv | 138 +++++++++++++
 tb/tb_exception_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and encodings for the exception unit and its system registers.
package exc_pkg;

  // Sequencing states of the exception unit
  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_TAKE      = 3'd1,
    ST_FLUSH_IN  = 3'd2,
    ST_HANDLER   = 3'd3,
    ST_FLUSH_OUT = 3'd4
  } exc_state_e;

  // ESR cause codes; DOUBLE is a flag bit OR-ed onto the existing cause
  localparam logic [3:0]  ESR_NONE       = 4'b0000;
  localparam logic [3:0]  ESR_BADOP      = 4'b0001;
  localparam logic [3:0]  ESR_IRQ        = 4'b0010;
  localparam int unsigned ESR_DOUBLE_BIT = 3;

  // MRS read selects
  typedef enum logic [1:0] {
    SEL_ELR  = 2'b00,
    SEL_ESR  = 2'b01,
    SEL_ERR  = 2'b10,
    SEL_ZERO = 2'b11
  } sysreg_sel_e;

  // Mark an existing syndrome as a double fault, keeping the original cause
  function automatic logic [3:0] esr_double(input logic [3:0] esr);
    logic [3:0] v;
    v                 = esr;
    v[ESR_DOUBLE_BIT] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/exc_sysregs.sv
// Exception system registers (ELR, ESR, sticky ERR) with load enables and
// a zero-latency read mux for MRS.
module exc_sysregs
  import exc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_elr_we,
  input  logic [63:0] i_elr_d,
  input  logic        i_esr_we,
  input  logic [3:0]  i_esr_d,
  input  logic        i_err_set,
  input  logic [1:0]  i_sel,
  output logic [63:0] o_elr,
  output logic [3:0]  o_esr,
  output logic        o_err,
  output logic [63:0] o_rdata
);

  logic [63:0] r_elr;
  logic [3:0]  r_esr;
  logic        r_err;

  // Register file update; ERR only ever sets and is cleared solely by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_elr <= '0;
      r_esr <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_elr_we)  r_elr <= i_elr_d;
      if (i_esr_we)  r_esr <= i_esr_d;
      if (i_err_set) r_err <= 1'b1;
    end
  end

  // Zero-extended combinational read select
  always_comb begin
    o_rdata = '0;
    unique case (sysreg_sel_e'(i_sel))
      SEL_ELR:  o_rdata = r_elr;
      SEL_ESR:  o_rdata = {60'd0, r_esr};
      SEL_ERR:  o_rdata = {63'd0, r_err};
      SEL_ZERO: o_rdata = '0;
      default:  o_rdata = '0;
    endcase
  end

  assign o_elr = r_elr;
  assign o_esr = r_esr;
  assign o_err = r_err;

endmodule

// File: rtl/exception_unit.sv
// Exception unit: detects bad opcodes and external interrupts, redirects to
// the handler vector, masks new events while the pipeline flushes, and
// handles exception return and double faults.
module exception_unit
  import exc_pkg::*;
#(
  parameter logic [63:0] EXC_VECTOR   = 64'h0000_0000_0000_00D8,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        NotAnInstr,
  input  logic        ERet,
  input  logic        ExtIAsserted,
  input  logic [63:0] PC,
  input  logic [1:0]  SysRegSel,
  output logic        Exc,
  output logic [63:0] ExcVector,
  output logic [63:0] ERetTarget,
  output logic        ExcAck,
  output logic        InException,
  output logic [63:0] SysRegData
);

  localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

  exc_state_e  r_state;
  logic [3:0]  r_cnt;
  logic        r_exc;
  logic        r_ack;
  logic        r_inexc;

  logic        w_take_bad;
  logic        w_take_irq;
  logic        w_double;
  logic        w_elr_we;
  logic        w_esr_we;
  logic [3:0]  w_esr_d;
  logic [63:0] w_elr;
  logic [3:0]  w_esr;
  logic        w_err;

  // Event detection; IRQ is only seen in RUN and loses to a bad opcode
  always_comb begin
    w_take_bad = (r_state == ST_RUN) && NotAnInstr;
    w_take_irq = (r_state == ST_RUN) && !NotAnInstr && ExtIAsserted;
    w_double   = (r_state == ST_HANDLER) && NotAnInstr;
    w_elr_we   = w_take_bad || w_take_irq;
    w_esr_we   = w_take_bad || w_take_irq || w_double;
    if (w_take_bad)      w_esr_d = ESR_BADOP;
    else if (w_take_irq) w_esr_d = ESR_IRQ;
    else                 w_esr_d = esr_double(w_esr);
  end

  exc_sysregs u_sysregs (
    .clk       (clk),
    .rst       (reset),
    .i_elr_we  (w_elr_we),
    .i_elr_d   (PC),
    .i_esr_we  (w_esr_we),
    .i_esr_d   (w_esr_d),
    .i_err_set (w_double),
    .i_sel     (SysRegSel),
    .o_elr     (w_elr),
    .o_esr     (w_esr),
    .o_err     (w_err),
    .o_rdata   (SysRegData)
  );

  // Sequencer with registered Exc/ExcAck/InException set on the entering edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_exc   <= 1'b0;
      r_ack   <= 1'b0;
      r_inexc <= 1'b0;
    end else begin
      r_exc <= 1'b0;
      r_ack <= 1'b0;
      unique case (r_state)
        ST_RUN: begin
          if (w_take_bad || w_take_irq) begin
            r_state <= ST_TAKE;
            r_exc   <= 1'b1;
            r_ack   <= w_take_irq;
            r_inexc <= 1'b1;
          end
        end
        ST_TAKE: begin
          r_state <= ST_FLUSH_IN;
          r_cnt   <= FC;
        end
        ST_FLUSH_IN: begin
          if (r_cnt <= 4'd1) begin
            r_state <= ST_HANDLER;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_HANDLER: begin
          if (w_double) begin
            r_state <= ST_TAKE;
            r_exc   <= 1'b1;
          end else if (ERet) begin
            r_state <= ST_FLUSH_OUT;
            r_cnt   <= FC;
            r_inexc <= 1'b0;
          end
        end
        ST_FLUSH_OUT: begin
          if (r_cnt <= 4'd1) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
          r_inexc <= 1'b0;
        end
      endcase
    end
  end

  assign Exc         = r_exc;
  assign ExcAck      = r_ack;
  assign InException = r_inexc;
  assign ExcVector   = EXC_VECTOR;
  assign ERetTarget  = w_elr;

  logic w_unused;
  assign w_unused = w_err;

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: vector table, directed corner sequences and
// randomized traffic against a cycle-timestamp reference model.
module tb_exception_unit;

  localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;
  localparam int          FC  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        NotAnInstr, ERet, ExtIAsserted;
  logic [63:0] PC;
  logic [1:0]  SysRegSel;
  logic        Exc, ExcAck, InException;
  logic [63:0] ExcVector, ERetTarget, SysRegData;

  int checks = 0;
  int errors = 0;

  exception_unit #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk          (clk),
    .reset        (reset),
    .NotAnInstr   (NotAnInstr),
    .ERet         (ERet),
    .ExtIAsserted (ExtIAsserted),
    .PC           (PC),
    .SysRegSel    (SysRegSel),
    .Exc          (Exc),
    .ExcVector    (ExcVector),
    .ERetTarget   (ERetTarget),
    .ExcAck       (ExcAck),
    .InException  (InException),
    .SysRegData   (SysRegData)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an exception episode is described by the cycle its
  // redirect appears (handler reachable FC+1 cycles later) and a return by
  // the cycle normal running resumes.
  longint      cyc;
  int          m_mode;      // 0 running, 1 in exception, 2 returning
  longint      m_exc_cyc;
  longint      m_ret_end;
  logic [63:0] m_elr;
  logic [3:0]  m_esr;
  logic        m_err;

  function automatic bit m_running(input longint p);
    return (m_mode == 0) || (m_mode == 2 && p >= m_ret_end);
  endfunction

  function automatic bit m_in_handler(input longint p);
    return (m_mode == 1) && (p >= m_exc_cyc + 1 + FC);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_exc_cyc = -1000; m_ret_end = 0;
    m_elr = '0; m_esr = '0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic nai, input logic eret, input logic irq,
                            input logic [63:0] pc);
    longint p;
    p = cyc;
    cyc++;
    if (m_running(p)) begin
      if (nai || irq) begin
        m_mode = 1; m_exc_cyc = cyc; m_elr = pc;
        m_esr = nai ? 4'd1 : 4'd2;
      end
    end else if (m_in_handler(p)) begin
      if (nai) begin
        m_mode = 1; m_exc_cyc = cyc; m_esr = m_esr | 4'b1000; m_err = 1'b1;
      end else if (eret) begin
        m_mode = 2; m_ret_end = cyc + FC;
      end
    end
  endtask

  function automatic logic [63:0] m_rdata(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_elr;
      2'd1:    return {60'd0, m_esr};
      2'd2:    return {63'd0, m_err};
      default: return 64'd0;
    endcase
  endfunction

  // One clock: drive at negedge, edge, compare against the model at negedge
  task automatic step(input logic nai, input logic eret, input logic irq,
                      input logic [63:0] pc, input logic [1:0] sel);
    logic m_exc;
    NotAnInstr = nai; ERet = eret; ExtIAsserted = irq; PC = pc; SysRegSel = sel;
    @(posedge clk);
    model_edge(nai, eret, irq, pc);
    @(negedge clk);
    m_exc = (m_mode == 1) && (cyc == m_exc_cyc);
    chk("Exc",         {63'd0, Exc},         {63'd0, m_exc});
    chk("ExcAck",      {63'd0, ExcAck},      {63'd0, m_exc && (m_esr == 4'd2)});
    chk("InException", {63'd0, InException}, {63'd0, (m_mode == 1)});
    chk("ERetTarget",  ERetTarget,           m_elr);
    chk("SysRegData",  SysRegData,           m_rdata(sel));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    NotAnInstr = 0; ERet = 0; ExtIAsserted = 0; PC = '0; SysRegSel = 2'd0;
    @(negedge clk);
    chk("rst_Exc",  {63'd0, Exc},         64'd0);
    chk("rst_Ack",  {63'd0, ExcAck},      64'd0);
    chk("rst_InEx", {63'd0, InException}, 64'd0);
    chk("rst_ELR",  ERetTarget,           64'd0);
    chk("rst_Vec",  ExcVector,            VEC);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        nai, eret, irq;
    logic [63:0] pc;
    logic [1:0]  sel;
    logic        exc, ack, inx;
    logic [63:0] elr, data;
  } vec_t;

  function automatic vec_t mk(input logic nai, input logic eret, input logic irq,
                              input logic [63:0] pc, input logic [1:0] sel,
                              input logic exc, input logic ack, input logic inx,
                              input logic [63:0] elr, input logic [63:0] data);
    vec_t v;
    v.nai = nai; v.eret = eret; v.irq = irq; v.pc = pc; v.sel = sel;
    v.exc = exc; v.ack = ack; v.inx = inx; v.elr = elr; v.data = data;
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    reset = 1'b1;
    cyc = 0;
    model_reset();

    // Bad opcode at 0x40: redirect, 3 masked flush cycles (ERet ignored),
    // handler return, 3 masked cycles (events ignored), then an IRQ taken.
    tbl[0] = mk(1, 0, 0, 64'h40,  2'd0, 1, 0, 1, 64'h40,  64'h40);
    tbl[1] = mk(0, 0, 0, 64'h44,  2'd1, 0, 0, 1, 64'h40,  64'h1);
    tbl[2] = mk(0, 0, 1, 64'h48,  2'd0, 0, 0, 1, 64'h40,  64'h40);
    tbl[3] = mk(0, 1, 0, 64'h4C,  2'd3, 0, 0, 1, 64'h40,  64'h0);
    tbl[4] = mk(0, 1, 1, 64'h50,  2'd2, 0, 0, 1, 64'h40,  64'h0);
    tbl[5] = mk(0, 1, 1, 64'h54,  2'd1, 0, 0, 0, 64'h40,  64'h1);
    tbl[6] = mk(1, 0, 0, 64'h200, 2'd0, 0, 0, 0, 64'h40,  64'h40);
    tbl[7] = mk(1, 0, 1, 64'h204, 2'd0, 0, 0, 0, 64'h40,  64'h40);
    tbl[8] = mk(1, 0, 1, 64'h208, 2'd0, 0, 0, 0, 64'h40,  64'h40);
    tbl[9] = mk(0, 0, 1, 64'h300, 2'd1, 1, 1, 1, 64'h300, 64'h2);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].nai, tbl[i].eret, tbl[i].irq, tbl[i].pc, tbl[i].sel);
      chk($sformatf("tbl%0d_Exc", i),  {63'd0, Exc},         {63'd0, tbl[i].exc});
      chk($sformatf("tbl%0d_Ack", i),  {63'd0, ExcAck},      {63'd0, tbl[i].ack});
      chk($sformatf("tbl%0d_InEx", i), {63'd0, InException}, {63'd0, tbl[i].inx});
      chk($sformatf("tbl%0d_ELR", i),  ERetTarget,           tbl[i].elr);
      chk($sformatf("tbl%0d_Data", i), SysRegData,           tbl[i].data);
    end

    // IRQ held: Exc and ExcAck together once, no retake while in handler
    do_reset();
    step(0, 0, 1, 64'h100, 2'd1);
    chk("irq_Exc", {63'd0, Exc}, 64'd1);
    chk("irq_Ack", {63'd0, ExcAck}, 64'd1);
    chk("irq_ESR", SysRegData, 64'd2);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 64'h104, 2'd0);
      chk("irq_noretake", {63'd0, Exc}, 64'd0);
    end
    chk("irq_InEx", {63'd0, InException}, 64'd1);

    // Simultaneous bad opcode and IRQ: bad opcode wins, IRQ taken after return
    do_reset();
    step(1, 0, 1, 64'h20, 2'd1);
    chk("both_ESR", SysRegData, 64'd1);
    chk("both_Ack", {63'd0, ExcAck}, 64'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 64'h24, 2'd1);
    step(0, 1, 1, 64'h28, 2'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 64'h2C, 2'd1);
      chk("both_masked", {63'd0, Exc}, 64'd0);
    end
    step(0, 0, 1, 64'h30, 2'd1);
    chk("both_irq_Exc", {63'd0, Exc}, 64'd1);
    chk("both_irq_ESR", SysRegData, 64'd2);
    chk("both_irq_ELR", ERetTarget, 64'h30);

    // Double fault in handler
    do_reset();
    step(1, 0, 0, 64'h40, 2'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 64'h44, 2'd0);
    step(1, 0, 0, 64'h99, 2'd1);
    chk("dbl_Exc", {63'd0, Exc}, 64'd1);
    chk("dbl_ESR", SysRegData, 64'h9);
    step(0, 0, 0, 64'h9C, 2'd2);
    chk("dbl_ERR", SysRegData, 64'd1);
    chk("dbl_ELR", ERetTarget, 64'h40);

    // Asynchronous reset mid-FLUSH_IN, then normal detection
    do_reset();
    step(1, 0, 0, 64'h40, 2'd0);
    step(0, 0, 0, 64'h44, 2'd0);
    #1 reset = 1'b1;
    #1;
    chk("arst_Exc",  {63'd0, Exc},         64'd0);
    chk("arst_Ack",  {63'd0, ExcAck},      64'd0);
    chk("arst_InEx", {63'd0, InException}, 64'd0);
    chk("arst_ELR",  ERetTarget,           64'd0);
    chk("arst_Data", SysRegData,           64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1, 0, 0, 64'h60, 2'd1);
    chk("arst_take_Exc", {63'd0, Exc}, 64'd1);
    chk("arst_take_ESR", SysRegData, 64'd1);
    chk("arst_take_ELR", ERetTarget, 64'h60);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 4) == 0), {$urandom, $urandom},
           2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
